// File: rtl/uartrx_pkg.sv
// Shared types and defaults for the UART receive controller.
// State encoding is fixed at 2 bits; defaults assume 100 MHz clock at 9600 baud.
package uartrx_pkg;
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DEF_DEPTH       = 4;
  localparam int DEF_TIMEOUT_CYC = 104160;
endpackage

// File: rtl/uartrx_fifo.sv
// First-word fall-through receive FIFO. A pop on a full FIFO frees the slot a
// same-cycle push writes into; a pop on an empty FIFO is ignored.
module uartrx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/uartrx_ctrl.sv
// UART receive controller: arms the receiver, captures completed bytes into a
// FIFO, flags dropped bytes and pulses once when the line idles with data held.
module uartrx_ctrl
  import uartrx_pkg::*;
#(
  parameter  int DEPTH       = DEF_DEPTH,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          rx_en,
  input  logic [7:0]    rx_dout,
  input  logic          rx_valid,
  input  logic          rd_req,
  output logic [7:0]    rd_data,
  output logic          rd_empty,
  output logic [CW-1:0] count,
  output logic          overrun,
  input  logic          ovr_clr,
  output logic          idle_timeout
);
  localparam int            TW     = $clog2(TIMEOUT_CYC + 2);
  localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_CYC + 1);

  state_t        state, state_nx;
  logic          rx_valid_q;
  logic          done;
  logic          full;
  logic          ovr_evt;
  logic [TW-1:0] idle_cnt;

  // Completion is the rising edge of rx_valid; ARM deliberately ignores it so a
  // frame already in flight at enable time never reaches the FIFO.
  assign done    = rx_valid & ~rx_valid_q & ((state == ST_RUN) | (state == ST_DRAIN));
  assign ovr_evt = done & full & ~rd_req;

  uartrx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (done),
    .pop   (rd_req),
    .wdata (rx_dout),
    .rdata (rd_data),
    .full  (full),
    .empty (rd_empty),
    .count (count)
  );

  always_comb begin
    state_nx = state;
    rx_en    = 1'b1;
    case (state)
      ST_OFF: begin
        rx_en = 1'b0;
        if (enable) state_nx = ST_ARM;
      end
      ST_ARM: begin
        if (!enable)       state_nx = ST_OFF;
        else if (rx_valid) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_nx = rx_valid ? ST_OFF : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (enable)    state_nx = ST_RUN;
        else if (done) state_nx = ST_OFF;
      end
      default: begin
        rx_en    = 1'b0;
        state_nx = ST_OFF;
      end
    endcase
  end

  // Counter parks one past the threshold so the pulse cannot repeat until a push.
  assign idle_timeout = (state == ST_RUN) & ~rd_empty & (idle_cnt == TO_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_OFF;
      rx_valid_q <= 1'b0;
      overrun    <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_nx;
      rx_valid_q <= rx_valid;
      if (ovr_evt)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      if (state != ST_RUN || done)
        idle_cnt <= '0;
      else if (!rd_empty && idle_cnt != TO_END)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_uartrx_ctrl.sv
// Randomized + directed bench for uartrx_ctrl against a queue-based reference
// model that applies the receive/FIFO/idle rules one clock at a time.
module tb_uartrx_ctrl;
  localparam int DEPTH = 4;
  localparam int TO    = 20;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int M_OFF = 0, M_ARM = 1, M_RUN = 2, M_DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable, rx_valid, rd_req, ovr_clr;
  logic [7:0]    rx_dout, rd_data;
  logic          rx_en, rd_empty, overrun, idle_timeout;
  logic [CW-1:0] count;

  int n_chk = 0;
  int n_err = 0;

  int             m_mode;
  bit             m_prev;
  bit             m_ovr;
  int             m_idle;
  byte unsigned   q[$];

  uartrx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rx_en        (rx_en),
    .rx_dout      (rx_dout),
    .rx_valid     (rx_valid),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .count        (count),
    .overrun      (overrun),
    .ovr_clr      (ovr_clr),
    .idle_timeout (idle_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF;
    m_prev = 1'b0;
    m_ovr  = 1'b0;
    m_idle = 0;
    q.delete();
  endtask

  // One rising edge of the reference, driven by the inputs held over it.
  task automatic model_step();
    bit done, evt;
    int nxt;
    done = rx_valid && !m_prev && (m_mode == M_RUN || m_mode == M_DRAIN);
    if (m_mode != M_RUN || done) m_idle = 0;
    else if (q.size() > 0)       m_idle++;
    if (rd_req && q.size() > 0) void'(q.pop_front());
    evt = 1'b0;
    if (done) begin
      if (q.size() < DEPTH) q.push_back(rx_dout);
      else                  evt = 1'b1;
    end
    if (evt)          m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    nxt = m_mode;
    case (m_mode)
      M_OFF:   if (enable) nxt = M_ARM;
      M_ARM:   if (!enable) nxt = M_OFF; else if (rx_valid) nxt = M_RUN;
      M_RUN:   if (!enable) nxt = rx_valid ? M_OFF : M_DRAIN;
      default: if (enable) nxt = M_RUN; else if (done) nxt = M_OFF;
    endcase
    m_mode = nxt;
    m_prev = rx_valid;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".rx_en"},    rx_en,        m_mode != M_OFF);
    chk({ph, ".count"},    count,        q.size());
    chk({ph, ".rd_empty"}, rd_empty,     q.size() == 0);
    chk({ph, ".overrun"},  overrun,      m_ovr);
    chk({ph, ".timeout"},  idle_timeout, m_mode == M_RUN && q.size() > 0 && m_idle == TO);
    if (q.size() > 0) chk({ph, ".rd_data"}, rd_data, q[0]);
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic cyc(input bit en, input bit v, input logic [7:0] d, input bit rd,
                     input bit clr, input string ph);
    enable   = en;
    rx_valid = v;
    rx_dout  = d;
    rd_req   = rd;
    ovr_clr  = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs(ph);
  endtask

  task automatic frame(input bit en, input logic [7:0] d, input bit rd, input string ph);
    cyc(en, 1'b0, 8'h00, 1'b0, 1'b0, ph);
    cyc(en, 1'b0, 8'h00, 1'b0, 1'b0, ph);
    cyc(en, 1'b1, d, rd, 1'b0, ph);
  endtask

  initial begin
    int pulses, at_k;
    bit r_en, r_v;
    rst = 1'b1; enable = 1'b0; rx_valid = 1'b0; rx_dout = 8'h00; rd_req = 1'b0; ovr_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.rx_en", rx_en, 0);
    chk("rst.count", count, 0);
    chk("rst.rd_empty", rd_empty, 1);
    chk("rst.overrun", overrun, 0);
    chk("rst.timeout", idle_timeout, 0);
    rst = 1'b0;

    // Enable mid-frame: arm, then the first rising rx_valid only starts RUN.
    repeat (50) cyc(1, 0, 8'hEE, 0, 0, "arm");
    cyc(1, 1, 8'hEE, 0, 0, "arm");
    cyc(1, 1, 8'hEE, 0, 0, "arm");
    chk("arm.count0", count, 0);
    chk("arm.rx_en1", rx_en, 1);

    frame(1, 8'h41, 0, "abc");
    frame(1, 8'h42, 0, "abc");
    frame(1, 8'h43, 0, "abc");
    chk("abc.count3", count, 3);
    chk("abc.head41", rd_data, 8'h41);
    cyc(1, 1, 8'h00, 1, 0, "abc");
    chk("abc.head42", rd_data, 8'h42);
    cyc(1, 1, 8'h00, 1, 0, "abc");
    chk("abc.head43", rd_data, 8'h43);
    cyc(1, 1, 8'h00, 1, 0, "abc");
    chk("abc.empty", rd_empty, 1);

    cyc(1, 1, 8'h00, 1, 0, "popempty");
    chk("popempty.count", count, 0);
    frame(1, 8'h99, 1, "pushpopempty");
    chk("pushpopempty.count", count, 1);
    cyc(1, 1, 8'h00, 1, 0, "pushpopempty");

    for (int i = 0; i < 5; i++) frame(1, 8'(8'h10 + i), 0, "ovr");
    chk("ovr.count4", count, 4);
    chk("ovr.flag", overrun, 1);
    chk("ovr.head10", rd_data, 8'h10);
    cyc(1, 1, 8'h00, 0, 1, "ovrclr");
    chk("ovrclr.flag", overrun, 0);

    frame(1, 8'h77, 1, "fullpop");
    chk("fullpop.count4", count, 4);
    chk("fullpop.noovr", overrun, 0);
    repeat (3) cyc(1, 1, 8'h00, 1, 0, "fullpop");
    chk("fullpop.last77", rd_data, 8'h77);
    cyc(1, 1, 8'h00, 1, 0, "fullpop");

    cyc(1, 0, 8'h00, 0, 0, "drain");
    cyc(0, 0, 8'h00, 0, 0, "drain");
    cyc(0, 0, 8'h00, 0, 0, "drain");
    chk("drain.rx_en1", rx_en, 1);
    cyc(0, 1, 8'h5A, 0, 0, "drain");
    chk("drain.rx_en0", rx_en, 0);
    chk("drain.count1", count, 1);
    chk("drain.data5a", rd_data, 8'h5A);
    cyc(0, 1, 8'h00, 1, 0, "drain");

    cyc(1, 1, 8'h00, 0, 0, "tmo");
    cyc(1, 1, 8'h00, 0, 0, "tmo");
    frame(1, 8'($urandom), 0, "tmo");
    pulses = 0; at_k = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc(1, 1, 8'h00, 0, 0, "tmo");
      if (idle_timeout === 1'b1) begin pulses++; at_k = k; end
    end
    chk("tmo.pulses", pulses, 1);
    chk("tmo.cycle", at_k, TO);
    cyc(1, 1, 8'h00, 1, 0, "tmo");

    // Two random regimes: busy line with frequent pops, then a slow line
    // that lets idle timeouts fire.
    r_en = 1'b1; r_v = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 700; i++) begin
        if ($urandom_range(0, 29) == 0) r_en = ~r_en;
        if ($urandom_range(0, (ph == 0) ? 3 : 35) == 0) r_v = ~r_v;
        cyc(r_en, r_v, 8'($urandom), $urandom_range(0, (ph == 0) ? 3 : 40) == 0,
            $urandom_range(0, 15) == 0, "rnd");
      end
    end

    // Asynchronous reset in the middle of a drain.
    cyc(1, 1, 8'h00, 0, 0, "arst");
    cyc(1, 1, 8'h00, 0, 0, "arst");
    frame(1, 8'h33, 0, "arst");
    cyc(1, 0, 8'h00, 0, 0, "arst");
    cyc(0, 0, 8'h00, 0, 0, "arst");
    #2 rst = 1'b1;
    #1;
    chk("arst.rx_en", rx_en, 0);
    chk("arst.count", count, 0);
    chk("arst.rd_empty", rd_empty, 1);
    chk("arst.overrun", overrun, 0);
    chk("arst.timeout", idle_timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc(0, 1, 8'h00, 0, 0, "post");
    cyc(1, 1, 8'h00, 0, 0, "post");
    cyc(1, 1, 8'h00, 0, 0, "post");
    frame(1, 8'hC3, 0, "post");
    chk("post.dataC3", rd_data, 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
